// File: rtl/usrt_rx.sv
// usrt_rx: synchronous serial receiver for the 40-slot, 4 x 6-bit character
// message. Samples rxd on bit strobes, checks start/stop/even-parity and
// hands the 24-bit word to the consumer over a valid/ack handshake.
module usrt_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_usrt,
  input  logic        rxd,
  input  logic        par_en,
  input  logic        ack,
  output logic        rts,
  output logic [23:0] data,
  output logic        valid,
  output logic        par_err,
  output logic        frm_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  slot_q, slot_d;
  logic [23:0] data_q, data_d;
  logic        par_err_q, par_err_d;
  logic        frm_err_q, frm_err_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        rts_q, rts_d;

  logic [1:0]  chr;        // character index 0..3
  logic [3:0]  pos;        // slot within the character 0..9
  logic [4:0]  char_base;  // bit offset of the current character in data
  logic [4:0]  bit_idx;    // data bit written by a data slot
  logic [5:0]  cur_char;

  // Split the running slot counter into character index and in-character slot.
  always_comb begin
    chr = 2'd0;
    pos = 4'(slot_q);
    if (slot_q >= 6'd30) begin
      chr = 2'd3;
      pos = 4'(slot_q - 6'd30);
    end else if (slot_q >= 6'd20) begin
      chr = 2'd2;
      pos = 4'(slot_q - 6'd20);
    end else if (slot_q >= 6'd10) begin
      chr = 2'd1;
      pos = 4'(slot_q - 6'd10);
    end
    char_base = 5'(chr) * 5'd6;
    bit_idx   = char_base + 5'(pos) - 5'd1;
    cur_char  = data_q[char_base +: 6];
  end

  // Next-state / accumulator logic for the receive sequencer.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    data_d    = data_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    case (state_q)
      IDLE: begin
        // Slot 0 of char 0 is consumed here; a low line is the first start bit.
        if (en_usrt && !rxd) begin
          state_d   = RECV;
          slot_d    = 6'd1;
          data_d    = '0;
          par_err_d = 1'b0;
          frm_err_d = 1'b0;
        end
      end
      RECV: begin
        if (en_usrt) begin
          if (pos == 4'd0) begin
            // Missing start bit: the rest of the message cannot be trusted.
            if (rxd) begin
              frm_err_d = 1'b1;
              state_d   = DONE;
            end
          end else if (pos <= 4'd6) begin
            data_d[bit_idx] = rxd;
          end else if (pos == 4'd7) begin
            if (^{cur_char, rxd}) par_err_d = 1'b1;
          end else begin
            if (!rxd) frm_err_d = 1'b1;
          end
          slot_d = (pos == 4'd6 && !par_en) ? slot_q + 6'd2 : slot_q + 6'd1;
          if (slot_q == 6'd39) state_d = DONE;
        end
      end
      DONE: begin
        if (ack) begin
          state_d = IDLE;
          slot_d  = 6'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == DONE);
    busy_d  = (state_d == RECV);
    rts_d   = (state_d != DONE);
  end

  // State and registered outputs; rts stays low while reset is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      rts_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      data_q    <= data_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      rts_q     <= rts_d;
    end
  end

  assign rts     = rts_q;
  assign data    = data_q;
  assign valid   = valid_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_usrt_rx.sv
// tb_usrt_rx: scoreboard bench for usrt_rx. Each message's expected word and
// flags are queued when its serial bits are generated and compared on valid.
module tb_usrt_rx;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_usrt = 1'b0;
  logic        rxd = 1'b1;
  logic        par_en = 1'b0;
  logic        ack = 1'b0;
  logic        rts, valid, par_err, frm_err, busy;
  logic [23:0] data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [23:0] d;
    logic        pe;
    logic        fe;
  } exp_t;
  exp_t sb[$];

  usrt_rx dut (
    .clk(clk), .rst(rst), .en_usrt(en_usrt), .rxd(rxd), .par_en(par_en),
    .ack(ack), .rts(rts), .data(data), .valid(valid), .par_err(par_err),
    .frm_err(frm_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // One strobe covering exactly one rising edge, then a random pause.
  task automatic strobe(input logic b);
    @(negedge clk);
    en_usrt = 1'b1;
    rxd = b;
    @(negedge clk);
    en_usrt = 1'b0;
    rxd = 1'b1;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Serialise a message; bad_slot inverts the bit of that slot, flip_par
  // inverts the parity of that character, stop_at truncates before a slot.
  // pre_busy/pre_valid are sampled just before the final strobe.
  task automatic send_msg(input logic [23:0] chars, input bit pen,
                          input int bad_slot, input int flip_par,
                          input int stop_at,
                          output logic pre_busy, output logic pre_valid);
    exp_t e;
    bit   abort;
    int   last;
    logic [5:0] ch;
    logic b;
    par_en = pen;
    abort = (bad_slot == 10 || bad_slot == 20 || bad_slot == 30);
    last  = abort ? bad_slot : 39;
    e.d   = abort ? (chars & ((24'h1 << (6 * (bad_slot / 10))) - 24'h1)) : chars;
    e.fe  = (bad_slot >= 0);
    e.pe  = pen && (flip_par >= 0) && !(abort && flip_par >= bad_slot / 10);
    if (stop_at < 0) sb.push_back(e);
    pre_busy  = 1'bx;
    pre_valid = 1'bx;
    for (int c = 0; c < 4; c++) begin
      ch = chars[c*6 +: 6];
      for (int p = 0; p < 10; p++) begin
        if (p == 7 && !pen) continue;
        if (c * 10 + p == stop_at) return;
        if (p == 0)      b = 1'b0;
        else if (p <= 6) b = ch[p-1];
        else if (p == 7) b = (^ch) ^ (flip_par == c);
        else             b = 1'b1;
        if (c * 10 + p == bad_slot) b = ~b;
        if (c * 10 + p == last) begin
          pre_busy  = busy;
          pre_valid = valid;
        end
        strobe(b);
        if (c * 10 + p == last) return;
      end
    end
  endtask

  // Wait a bounded number of cycles for valid.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #23;
    checks++;
    if ({rts, valid, busy, par_err, frm_err} !== 5'b0 || data !== 24'h0) begin
      errors++;
      $display("FAIL reset_hold: rts/valid/busy/pe/fe=%b data=%h required 00000 000000",
               {rts, valid, busy, par_err, frm_err}, data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rts !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rts=%b busy=%b valid=%b required 1 0 0", rts, busy, valid);
    end
    // ack outside DONE must be ignored
    do_ack();
    checks++;
    if (valid !== 1'b0 || rts !== 1'b1) begin
      errors++;
      $display("FAIL ack_idle: valid=%b rts=%b required 0 1", valid, rts);
    end
  endtask

  // Pops the head of the scoreboard and compares it with the output.
  task automatic test_message(input string name, input logic [23:0] chars,
                              input bit pen, input int bad_slot, input int flip_par);
    logic pb, pv;
    bit ok;
    exp_t e;
    send_msg(chars, pen, bad_slot, flip_par, -1, pb, pv);
    checks++;
    if (pb !== 1'b1 || pv !== 1'b0) begin
      errors++;
      $display("FAIL %s_len: before last strobe busy=%b valid=%b required 1 0", name, pb, pv);
    end
    wait_valid(ok);
    e = sb.pop_front();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_valid: timeout waiting for valid", name);
    end
    checks++;
    if (data !== e.d || par_err !== e.pe || frm_err !== e.fe) begin
      errors++;
      $display("FAIL %s_out: data=%h pe=%b fe=%b required data=%h pe=%b fe=%b",
               name, data, par_err, frm_err, e.d, e.pe, e.fe);
    end
    checks++;
    if (rts !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: rts=%b busy=%b required 0 0", name, rts, busy);
    end
    do_ack();
    checks++;
    if (valid !== 1'b0 || rts !== 1'b1) begin
      errors++;
      $display("FAIL %s_ack: valid=%b rts=%b required 0 1", name, valid, rts);
    end
  endtask

  task automatic test_hold();
    logic pb, pv;
    bit ok;
    exp_t e;
    send_msg(24'h5A3C71, 1'b1, -1, -1, -1, pb, pv);
    wait_valid(ok);
    e = sb.pop_front();
    for (int i = 0; i < 100; i++) strobe(i[0]);
    checks++;
    if (!ok || valid !== 1'b1 || data !== e.d || rts !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold: valid=%b data=%h rts=%b busy=%b required 1 %h 0 0",
               valid, data, rts, busy, e.d);
    end
    // ack and a start-looking strobe on the same edge: start must not be taken
    @(negedge clk);
    ack = 1'b1;
    en_usrt = 1'b1;
    rxd = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    en_usrt = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || rts !== 1'b1) begin
      errors++;
      $display("FAIL ack_start: busy=%b valid=%b rts=%b required 0 0 1", busy, valid, rts);
    end
    test_message("after_hold", 24'h123456, 1'b0, -1, -1);
  endtask

  task automatic test_reset_mid();
    logic pb, pv;
    send_msg(24'hABCDEF, 1'b1, 18, 1, 25, pb, pv);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy=%b required 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({rts, valid, busy, par_err, frm_err} !== 5'b0 || data !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset: rts/valid/busy/pe/fe=%b data=%h required 00000 000000",
               {rts, valid, busy, par_err, frm_err}, data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rts !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: rts=%b valid=%b required 1 0", rts, valid);
    end
    test_message("after_reset", 24'h03FA95, 1'b1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_message("nopar",     24'h03FA95, 1'b0, -1, -1);
    test_message("par_good",  24'h03FA95, 1'b1, -1, -1);
    test_message("par_flip2", 24'h03FA95, 1'b1, -1, 2);
    test_message("stop18",    24'h03FA95, 1'b1, 18, -1);
    test_message("stop_np",   24'hC0FFEE, 1'b0, 39, -1);
    test_message("abort20",   24'h03FA95, 1'b1, 20, -1);
    test_message("abort10np", 24'hFFFFFF, 1'b0, 10, 3);
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/usrt_rx.md
# usrt_rx

Synchronous serial (USRT) receiver: the far-end counterpart of the team's slot-counting transmitter. It samples `rxd` on each `en_usrt` bit strobe, tracks the same 40-slot message structure (4 characters × 10 slots, parity slot optional), deserialises four 6-bit characters into one 24-bit word, checks parity and stop bits, and presents the result on a valid/ack handshake. Its `rts` output drives the transmitter's RTS input for flow control.

## Interface
Parameters: none; frame geometry is fixed.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en_usrt`  in  1  bit strobe, one `clk` wide; `rxd` is sampled only on edges where it is 1
- `rxd`  in  1  serial line, idle high
- `par_en`  in  1  1 = parity slot present (even parity); must be stable for a whole message
- `ack`  in  1  consumer accepts `data`/flags
- `rts`  out  1  ready to receive; to transmitter RTS
- `data`  out  24  char0 in [5:0], char1 [11:6], char2 [17:12], char3 [23:18]; LSB first within each char
- `valid`  out  1  message complete, held until `ack`
- `par_err`  out  1  one or more characters failed parity (valid with `valid`)
- `frm_err`  out  1  bad start or stop bit somewhere in the message (valid with `valid`)
- `busy`  out  1  message reception in progress

## Operation
- Slot map per character (slot = counter mod 10): 0 start (must be 0), 1–6 data bits d0..d5, 7 parity (only if `par_en`), 8–9 stop (must be 1). If `!par_en`, slot 7 is skipped: counter advances 6 → 8.
- 6-bit slot counter `slot`, 0..39; message = slots 0..39 back-to-back, no idle between characters.
- States:
  - IDLE: `rts`=1, `busy`=0. On strobe with `rxd`=0 → RECV, `slot`←1, clear data/err accumulators. Strobe with `rxd`=1 stays IDLE.
  - RECV: `busy`=1. Each strobe: handle current slot, then `slot`←`slot`+2 if (`slot` mod 10 = 6 and `!par_en`), else `slot`+1.
    - Data slot: shift bit into current character position.
    - Parity slot: if XOR(6 data bits, rxd) = 1 → set `par_err`.
    - Stop slot with `rxd`=0 → set `frm_err`, continue.
    - Start slot (10, 20, 30) with `rxd`=1 → set `frm_err`, go to DONE immediately (abort; remaining chars of `data` are 0).
    - Slot 39 handled → DONE.
  - DONE: `valid`=1, `rts`=0, `busy`=0; outputs frozen. `ack`=1 → IDLE next edge. Strobes/`rxd` ignored.
- `par_err`/`frm_err` accumulate over the message, cleared on entry to RECV.
- `en_usrt` low: no state change (transmitter pause on RTS is invisible except as stretched time).

## Timing
- Reset (async, `rst`=0): state IDLE, `slot`=0, `data`=0, `valid`=0, `par_err`=0, `frm_err`=0, `busy`=0, `rts`=1 — `rts` is held 0 while `rst` is asserted, goes 1 on first edge after release.
- `valid` rises on the same `clk` edge that samples slot 39 (or the aborting start slot); visible the following cycle.
- `ack` sampled only in DONE; `valid` falls and `rts` rises on that edge. `ack` outside DONE is ignored.
- `ack` and a strobe with `rxd`=0 on the same edge in DONE: start not taken (earliest start = next strobe after IDLE entry).
- Reset mid-message: everything returns to reset values immediately; partial message discarded, no `valid`.
- Message length: 40 strobes with `par_en`=1, 36 with `par_en`=0.

## Test plan
- No parity, chars 0x15,0x2A,0x3F,0x00, good stops → after 36th strobe `valid`=1, `data`=0x00FAA15? (exact: {0x00,0x3F,0x2A,0x15} = 0x03FA95), `par_err`=0, `frm_err`=0; `ack` → `valid`=0, `rts`=1.
- Parity on, same chars with correct even parity → 40 strobes, `data`=0x03FA95, both errors 0; flip parity of char2 → `par_err`=1 only.
- Stop bit slot 18 driven 0 → message still completes at slot 39, `frm_err`=1, `data` otherwise correct.
- Start slot 20 driven 1 → `valid`=1 right after that strobe, `frm_err`=1, `data`[23:12]=0, `busy`=0.
- Hold `ack`=0 for 100 strobes after `valid` with `rxd` toggling → `data` unchanged, `rts`=0; then `ack` → next message received normally.
- Assert `rst`=0 at slot 25 → all outputs reset values asynchronously; subsequent full message decoded correctly.
